// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the fetch FSM state encoding, the fault/idle data word and parameter defaults.
package imem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int          DEPTH_LOG2_DEF  = 10;
  localparam int          WAIT_CYCLES_DEF = 2;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Word storage: one synchronous write port and one registered read port.
// A read and a write to the same word on one edge returns the old contents.
module imem_array #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  // Both ports in one process: the read samples mem_q before the write lands.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder with a fixed number of wait states per fetch.
// Handshake: a request is taken on any rising edge where ReqValid & ReqReady; the response is a one-cycle RespValid pulse with no backpressure.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_IM_mem_ReqValid,
  input  logic [31:0] i_IM_mem_Addr,
  output logic        o_IM_mem_ReqReady,
  output logic        o_IM_mem_RespValid,
  output logic [31:0] o_IM_mem_DataR,
  output logic        o_IM_mem_Fault,
  input  logic        i_IM_load_WrEn,
  input  logic [31:0] i_IM_load_WrAddr,
  input  logic [31:0] i_IM_load_WrData,
  output imem_state_e o_dbg_state
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  imem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q;
  logic        ready_en_q;

  logic        accept;
  logic        rd_en;
  logic [31:0] rd_addr, rd_off, wr_off;
  logic        rd_fault, wr_hit;
  logic [31:0] rd_word;

  assign o_IM_mem_ReqReady = ready_en_q && (state_q != S_WAIT);
  assign accept            = i_IM_mem_ReqValid && o_IM_mem_ReqReady;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_addr = addr_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (state_q == S_RESP) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          addr_d  = i_IM_mem_Addr;
          rd_addr = i_IM_mem_Addr;
          cnt_d   = WAIT_LD;
          state_d = (WAIT_LD == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The array is read on the edge that enters RESP; with zero wait states that
  // is the accepting edge itself, so the live request address is used then.
  assign rd_en    = (state_d == S_RESP);
  assign rd_off   = (rd_addr - BASE_ADDR) >> 2;
  assign rd_fault = (rd_addr[1:0] != 2'b00) || ((rd_off >> DEPTH_LOG2) != 32'd0);

  assign wr_off = ((i_IM_load_WrAddr & ~32'h3) - BASE_ADDR) >> 2;
  assign wr_hit = i_IM_load_WrEn && ((wr_off >> DEPTH_LOG2) == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      fault_q    <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ready_en_q <= 1'b1;
      if (rd_en) begin
        fault_q <= rd_fault;
      end
    end
  end

  imem_array #(.AW(DEPTH_LOG2)) u_array (
    .clk_i   (clk),
    .we_i    (wr_hit),
    .waddr_i (wr_off[DEPTH_LOG2-1:0]),
    .wdata_i (i_IM_load_WrData),
    .re_i    (rd_en),
    .raddr_i (rd_off[DEPTH_LOG2-1:0]),
    .rdata_o (rd_word)
  );

  assign o_IM_mem_RespValid = (state_q == S_RESP);
  assign o_IM_mem_Fault     = o_IM_mem_RespValid && fault_q;
  assign o_IM_mem_DataR     = (o_IM_mem_RespValid && !fault_q) ? rd_word : NOP_WORD;
  assign o_dbg_state        = state_q;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, sets word-array depth to 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, sets wait states inserted per fetch.
REQ-003 Parameter BASE_ADDR, default 32'h0, is the byte address of word 0.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_IM_mem_ReqValid  input  1  fetch request present.
REQ-007 i_IM_mem_Addr  input  32  fetch byte address (the fetch stage PC).
REQ-008 o_IM_mem_ReqReady  output  1  request accepted this cycle when high together with ReqValid.
REQ-009 o_IM_mem_RespValid  output  1  single-cycle pulse marking a valid response.
REQ-010 o_IM_mem_DataR  output  32  instruction word; meaningful only while RespValid=1.
REQ-011 o_IM_mem_Fault  output  1  response is for a misaligned or out-of-range address.
REQ-012 i_IM_load_WrEn  input  1  program-load write strobe.
REQ-013 i_IM_load_WrAddr  input  32  load byte address; bits [1:0] ignored.
REQ-014 i_IM_load_WrData  input  32  load word.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 ReqReady = 1 in IDLE and RESP, 0 in WAIT; a request is accepted on any edge where ReqValid & ReqReady.
REQ-017 On accept, Addr is captured and the wait counter is loaded with WAIT_CYCLES; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-018 In WAIT, the counter decrements each cycle; WAIT->RESP on the edge where the counter goes from 1 to 0.
REQ-019 Latency: RespValid asserts exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 RESP lasts one cycle; from RESP, an accepted request proceeds per REQ-017, otherwise the next state is IDLE.
REQ-021 Throughput with continuous requests: one response per WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0, one response per cycle.
REQ-022 Word index = (Addr - BASE_ADDR) >> 2, computed modulo 2**32.
REQ-023 Fault = 1 when Addr[1:0] != 0 or word index >= 2**DEPTH_LOG2; DataR = 32'h00000000 (NOP) when faulted.
REQ-024 No response backpressure: the consumer must take the response in the RespValid cycle.
REQ-025 Load writes occur on every edge with WrEn=1, in any state, and do not affect ReqReady.
REQ-026 Out-of-range load addresses (same rule as REQ-023, alignment ignored) are dropped silently.
REQ-027 Read data is sampled on the edge entering RESP with read-before-write: a same-edge write to the same word is not visible in that response.

Reset
REQ-028 While rst=1: state IDLE, counter 0, captured address 0.
REQ-029 While rst=1: RespValid=0, Fault=0, DataR=0, ReqReady=0; ReqReady=1 from the first edge after release.
REQ-030 Reset mid-WAIT or mid-RESP abandons the fetch; no RespValid is ever produced for it.
REQ-031 Array contents are not reset.

Structure
REQ-032 Package imem_pkg holds the state enum, the NOP constant, and the parameter defaults.
REQ-033 Sub-module imem_array holds the storage: one synchronous write port and one synchronous read-before-write read port.

Verification
REQ-034 WAIT_CYCLES=2: load 32'h2408000A at 0x0, accept fetch 0x0 -> RespValid at accept+3 with DataR=32'h2408000A, Fault=0; ReqReady=0 for the 2 wait cycles.
REQ-035 WAIT_CYCLES=0: ReqValid held high with Addr 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive RespValid pulses with the matching words.
REQ-036 Fetch 0x6 -> Fault=1, DataR=0; fetch 0x1000 with DEPTH_LOG2=10 -> Fault=1, DataR=0.
REQ-037 Write 0xDEADBEEF to 0x8 on the same edge that enters RESP for 0x8 -> that response returns the old word; a refetch of 0x8 returns 0xDEADBEEF.
REQ-038 rst asserted in WAIT -> no RespValid; after release, ReqReady=1 and a fresh fetch completes normally.
